// File: rtl/sobel_pkg.sv
// sobel_pkg
// Shared definitions for the Sobel 3x3 window generator.
//   DATA_WIDTH_DEF : default pixel width in bits
//   WIN_ELEMS      : number of pixels in one window (3x3)
//   win_offset()   : bit offset of window element (r,c) inside the packed
//                    window; r = row (0 = oldest line), c = column
//                    (0 = oldest pixel). Element (2,2) is the newest pixel
//                    and sits in the least significant bits.
package sobel_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int WIN_ELEMS      = 9;

  function automatic int win_offset(input int r, input int c, input int dw);
    return ((2 - c) * 3 + (2 - r)) * dw;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer
// Simple dual-port line RAM holding one image line.
// Reads are registered; a read and a write to the same address in the same
// cycle return the old contents (read-before-write).
// Ports:
//   clk     : clock, rising edge
//   rd_en   : read enable, rd_data updates only when high
//   rd_addr : read address (pixel column)
//   rd_data : registered read data
//   wr_en   : write enable
//   wr_addr : write address (pixel column)
//   wr_data : write data
// The storage is not reset.
module sobel_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  // Index only as many address bits as the depth needs.
  localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_WIDTH-1:0]  rd_idx;
  logic [IDX_WIDTH-1:0]  wr_idx;

  assign rd_idx = rd_addr[IDX_WIDTH-1:0];
  assign wr_idx = wr_addr[IDX_WIDTH-1:0];

  // Non-blocking read and write in one process give read-before-write.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/sobel_window_gen_3x3.sv
// sobel_window_gen_3x3
// Turns a raster pixel stream into packed 3x3 windows for the Sobel stage.
// Two line buffers keep the previous two lines; a window is emitted for
// every pixel whose full 3x3 neighbourhood lies inside the current frame.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous reset, active low
//   in_valid  : pixel beat qualifier
//   in_sof    : start of frame, forces the beat to be pixel (0,0)
//   in_data   : pixel value
//   out_valid : one-cycle strobe per window, 2 clk after the completing beat
//   out_sof   : first window of a frame
//   out_eol   : last window of a line
//   out_data  : packed window, element (r,c) at sobel_pkg::win_offset(r,c)
// Optional (macro SOBEL_WIN_COORD_EN):
//   out_x, out_y : window centre coordinate, registered with out_data
module sobel_window_gen_3x3
  import sobel_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic                            in_sof,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            out_valid,
  output logic                            out_sof,
  output logic                            out_eol,
  output logic [WIN_ELEMS*DATA_WIDTH-1:0] out_data
`ifdef SOBEL_WIN_COORD_EN
  ,
  output logic [ADDR_WIDTH-1:0]           out_x,
  output logic [ADDR_WIDTH-1:0]           out_y
`endif
);

  localparam int WIN_BITS  = WIN_ELEMS * DATA_WIDTH;
  localparam int COLS_BITS = 6 * DATA_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] X_LAST = ADDR_WIDTH'(IMG_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] Y_LAST = ADDR_WIDTH'(IMG_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] TWO    = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ONE    = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] x_cnt, y_cnt;
  logic [ADDR_WIDTH-1:0] cur_x, cur_y;
  logic [ADDR_WIDTH-1:0] nxt_x, nxt_y;

  logic                  v1;
  logic [DATA_WIDTH-1:0] pix1;
  logic [ADDR_WIDTH-1:0] x1, y1;
  logic [DATA_WIDTH-1:0] lb0_q, lb1_q;

  logic                  emit;
  logic [COLS_BITS-1:0]  win_cols;
  logic [WIN_BITS-1:0]   next_win;

  // A start-of-frame beat is pixel (0,0) whatever the counters say.
  always_comb begin
    cur_x = in_sof ? '0 : x_cnt;
    cur_y = in_sof ? '0 : y_cnt;
    nxt_x = cur_x + ONE;
    nxt_y = cur_y;
    if (cur_x == X_LAST) begin
      nxt_x = '0;
      nxt_y = (cur_y == Y_LAST) ? '0 : cur_y + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (in_valid) begin
      x_cnt <= nxt_x;
      y_cnt <= nxt_y;
    end
  end

  // LB1 holds line y-1: it is rewritten with the incoming pixel on the beat.
  sobel_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_lb1 (
    .clk     (clk),
    .rd_en   (in_valid),
    .rd_addr (cur_x),
    .rd_data (lb1_q),
    .wr_en   (in_valid),
    .wr_addr (cur_x),
    .wr_data (in_data)
  );

  // LB0 holds line y-2. It takes the old LB1 word once that read has been
  // registered, so its write trails the beat by one cycle at the delayed x.
  // The only way the next beat can read that same address in that cycle is a
  // resync beat right after an x=0 beat; that beat is on line 0, whose
  // line-buffer data is never part of an emitted window.
  sobel_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_lb0 (
    .clk     (clk),
    .rd_en   (in_valid),
    .rd_addr (cur_x),
    .rd_data (lb0_q),
    .wr_en   (v1),
    .wr_addr (x1),
    .wr_data (lb1_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      pix1 <= '0;
      x1   <= '0;
      y1   <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        pix1 <= in_data;
        x1   <= cur_x;
        y1   <= cur_y;
      end
    end
  end

  assign emit = v1 && (x1 >= TWO) && (y1 >= TWO);

  // Shift the window one column towards column 0 and insert the new column.
  // win_cols keeps only columns 1 and 2 of the last shift, which become
  // columns 0 and 1 of the next window.
  always_comb begin
    next_win = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2; c++) begin
        next_win[win_offset(r, c, DATA_WIDTH) +: DATA_WIDTH] =
          win_cols[win_offset(r, c + 1, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
    next_win[win_offset(0, 2, DATA_WIDTH) +: DATA_WIDTH] = lb0_q;
    next_win[win_offset(1, 2, DATA_WIDTH) +: DATA_WIDTH] = lb1_q;
    next_win[win_offset(2, 2, DATA_WIDTH) +: DATA_WIDTH] = pix1;
  end

  // The window shifts on every delayed beat; out_data only updates when a
  // window is emitted so it holds between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cols  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= emit;
      out_sof   <= emit && (x1 == TWO) && (y1 == TWO);
      out_eol   <= emit && (x1 == X_LAST);
      if (v1) begin
        win_cols <= next_win[COLS_BITS-1:0];
      end
      if (emit) begin
        out_data <= next_win;
      end
    end
  end

`ifdef SOBEL_WIN_COORD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_x <= '0;
      out_y <= '0;
    end else if (emit) begin
      out_x <= x1 - ONE;
      out_y <= y1 - ONE;
    end
  end
`endif

endmodule

// File: tb/tb_sobel_window_gen_3x3.sv
// tb_sobel_window_gen_3x3
// Self-checking bench for sobel_window_gen_3x3 with an 8x6 image.
// Every driven beat updates a bench-side image model; beats that complete a
// window push the expected window onto a scoreboard, which the output
// monitor pops and compares on each out_valid.
// Optional macro SOBEL_WIN_COORD_EN also checks out_x/out_y.
module tb_sobel_window_gen_3x3;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_sof;
  logic          out_eol;
  logic [9*DW-1:0] out_data;
`ifdef SOBEL_WIN_COORD_EN
  logic [AW-1:0] out_x;
  logic [AW-1:0] out_y;
`endif

  sobel_window_gen_3x3 #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_data  (out_data)
`ifdef SOBEL_WIN_COORD_EN
    ,
    .out_x     (out_x),
    .out_y     (out_y)
`endif
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [71:0] data;
    logic        sof;
    logic        eol;
    int          x;
    int          y;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  img [H][W];
  int          mx = 0;
  int          my = 0;
  int          win_count = 0;
  logic [71:0] first_win = '0;
  logic [71:0] last_win = '0;
  logic        last_eol = 1'b0;
  logic        last_sof = 1'b0;

  task automatic checkOutput(input string tag, input logic [71:0] actual,
                             input logic [71:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic sof, input logic [7:0] data);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = data;
    if (sof) begin
      mx = 0;
      my = 0;
    end
    img[my][mx] = data;
    if (mx >= 2 && my >= 2) begin
      e.data = {img[my-2][mx-2], img[my-1][mx-2], img[my][mx-2],
                img[my-2][mx-1], img[my-1][mx-1], img[my][mx-1],
                img[my-2][mx],   img[my-1][mx],   img[my][mx]};
      e.sof  = (mx == 2 && my == 2);
      e.eol  = (mx == W - 1);
      e.x    = mx - 1;
      e.y    = my - 1;
      e.cyc  = cycle + 2;
      sb.push_back(e);
    end
    mx++;
    if (mx == W) begin
      mx = 0;
      my = (my == H - 1) ? 0 : my + 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
  endtask

  // One beat whose pixel value encodes the position it is expected to land on.
  task automatic beat(input logic sof);
    logic [7:0] d;
    d = sof ? 8'h00 : 8'(my * 16 + mx);
    applyStimulus(sof, d);
  endtask

  task automatic runFrame(input bit with_sof, input int gap_max, input bit rnd);
    logic [7:0] d;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        d = rnd ? 8'($urandom) : 8'(y * 16 + x);
        applyStimulus(with_sof && x == 0 && y == 0, d);
        if (gap_max > 0) idle($urandom_range(0, gap_max));
      end
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    idle(1);
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    #1;
    checkOutput(tag, 72'(sb.size()), 72'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        win_count++;
        last_win = out_data;
        last_eol = out_eol;
        last_sof = out_sof;
        if (out_sof) first_win = out_data;
        if (sb.size() == 0) begin
          checkOutput("unexpected_window", 72'(out_valid), 72'd0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("win_data", out_data, mon_e.data);
          checkOutput("win_sof", 72'(out_sof), 72'(mon_e.sof));
          checkOutput("win_eol", 72'(out_eol), 72'(mon_e.eol));
          checkOutput("win_latency", 72'(cycle), 72'(mon_e.cyc));
`ifdef SOBEL_WIN_COORD_EN
          checkOutput("win_x", 72'(out_x), 72'(mon_e.x));
          checkOutput("win_y", 72'(out_y), 72'(mon_e.y));
`endif
        end
      end else begin
        checkOutput("idle_sof", 72'(out_sof), 72'd0);
        checkOutput("idle_eol", 72'(out_eol), 72'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", 72'(out_valid), 72'd0);
    checkOutput("reset_sof", 72'(out_sof), 72'd0);
    checkOutput("reset_eol", 72'(out_eol), 72'd0);
    checkOutput("reset_data", out_data, 72'd0);
    rst_n = 1'b1;

    // Continuous frame with known pixel pattern.
    $display("[TB] continuous frame");
    win_count = 0;
    runFrame(1'b1, 0, 1'b0);
    drain("drain_continuous");
    checkOutput("count_continuous", 72'(win_count), 72'd24);
    checkOutput("first_win", first_win, 72'h00_10_20_01_11_21_02_12_22);
    checkOutput("last_win", last_win, 72'h35_45_55_36_46_56_37_47_57);
    checkOutput("last_eol", 72'(last_eol), 72'd1);
    checkOutput("last_sof", 72'(last_sof), 72'd0);

    // Same frame with random gaps between beats.
    $display("[TB] frame with random gaps");
    win_count = 0;
    first_win = '0;
    runFrame(1'b1, 5, 1'b0);
    drain("drain_gaps");
    checkOutput("count_gaps", 72'(win_count), 72'd24);
    checkOutput("first_win_gaps", first_win, 72'h00_10_20_01_11_21_02_12_22);

    // Two frames back to back.
    $display("[TB] back-to-back frames");
    win_count = 0;
    first_win = '0;
    runFrame(1'b1, 0, 1'b0);
    runFrame(1'b1, 0, 1'b0);
    drain("drain_b2b");
    checkOutput("count_b2b", 72'(win_count), 72'd48);
    checkOutput("first_win_b2b", first_win, 72'h00_10_20_01_11_21_02_12_22);

    // Random pixel data.
    $display("[TB] random data frame");
    win_count = 0;
    runFrame(1'b1, 2, 1'b1);
    drain("drain_random");
    checkOutput("count_random", 72'(win_count), 72'd24);

    // Resync: in_sof on the beat that would have been (4,3).
    $display("[TB] mid-line resync");
    win_count = 0;
    first_win = '0;
    for (int n = 0; n < 3 * W + 4; n++) beat(n == 0);
    beat(1'b1);
    for (int n = 1; n < W * H; n++) beat(1'b0);
    drain("drain_resync");
    checkOutput("count_resync", 72'(win_count), 72'd32);
    checkOutput("first_win_resync", first_win, 72'h00_10_20_01_11_21_02_12_22);

    // Reset pulsed mid-frame after a window has been emitted.
    $display("[TB] mid-frame reset");
    for (int n = 0; n < 3 * W + 6; n++) beat(n == 0);
    drain("drain_pre_reset");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", 72'(out_valid), 72'd0);
    checkOutput("async_reset_data", out_data, 72'd0);
    checkOutput("async_reset_sof", 72'(out_sof), 72'd0);
    checkOutput("async_reset_eol", 72'(out_eol), 72'd0);
    sb.delete();
    mx = 0;
    my = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    win_count = 0;
    first_win = '0;
    for (int n = 0; n < W * H; n++) beat(1'b0);
    drain("drain_post_reset");
    checkOutput("count_post_reset", 72'(win_count), 72'd24);
    checkOutput("first_win_post_reset", first_win, 72'h00_10_20_01_11_21_02_12_22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
